// File: rtl/serial_subtractor_if.sv
// Operand and result stream bundle for the digit-serial subtractor.
// The master drives operands and accepts results; the slave computes them.
interface serial_subtractor_if #(
    parameter int DATA_WID = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_WID-1:0] a;
    logic [DATA_WID-1:0] b;
    logic                enable;
    logic [DATA_WID-1:0] out;
    logic                borrow;
    logic                overflow;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_valid, a, b, enable, out_ready,
        input  in_ready, out, borrow, overflow, out_valid
    );

    modport slave (
        input  in_valid, a, b, enable, out_ready,
        output in_ready, out, borrow, overflow, out_valid
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: out = a - b, DIGIT_WID bits per RUN cycle,
// with unsigned borrow and signed overflow flags.
module serial_subtractor #(
    parameter int DATA_WID  = 8,
    parameter int DIGIT_WID = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_subtractor_if.slave    bus
);
    localparam int N     = DATA_WID / DIGIT_WID;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int MSB   = DATA_WID - 1;

    generate
        if (DATA_WID % DIGIT_WID != 0) begin : g_bad_digit
            $error("DIGIT_WID must divide DATA_WID");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [DATA_WID-1:0]  r_a_sh;
    logic [DATA_WID-1:0]  r_b_sh;
    logic [DATA_WID-1:0]  r_res;
    logic                 r_borrow_run;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_a_sign;
    logic                 r_b_sign;
    logic [DATA_WID-1:0]  r_out;
    logic                 r_borrow;
    logic                 r_overflow;
    logic                 r_out_valid;
    logic                 r_in_ready;

    logic [DIGIT_WID:0]          w_d;
    logic [DATA_WID+DIGIT_WID-1:0] w_cat;
    logic [DATA_WID-1:0]         w_res_next;
    logic                        w_last;

    // Top bit of the widened digit difference is the outgoing borrow.
    assign w_d = {1'b0, r_a_sh[DIGIT_WID-1:0]}
               - {1'b0, r_b_sh[DIGIT_WID-1:0]}
               - {{DIGIT_WID{1'b0}}, r_borrow_run};

    assign w_cat      = {w_d[DIGIT_WID-1:0], r_res};
    assign w_res_next = w_cat[DATA_WID+DIGIT_WID-1:DIGIT_WID];
    assign w_last     = (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_res        <= '0;
            r_borrow_run <= 1'b0;
            r_cnt        <= '0;
            r_a_sign     <= 1'b0;
            r_b_sign     <= 1'b0;
            r_out        <= '0;
            r_borrow     <= 1'b0;
            r_overflow   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh       <= bus.a;
                        r_b_sh       <= bus.b;
                        r_a_sign     <= bus.a[MSB];
                        r_b_sign     <= bus.b[MSB];
                        r_borrow_run <= 1'b0;
                        r_cnt        <= '0;
                        r_in_ready   <= 1'b0;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        r_res        <= w_res_next;
                        r_a_sh       <= r_a_sh >> DIGIT_WID;
                        r_b_sh       <= r_b_sh >> DIGIT_WID;
                        r_borrow_run <= w_d[DIGIT_WID];
                        r_cnt        <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_out       <= w_res_next;
                            r_borrow    <= w_d[DIGIT_WID];
                            r_overflow  <= (r_a_sign != r_b_sign)
                                         & (w_res_next[MSB] != r_a_sign);
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out       = r_out;
    assign bus.borrow    = r_borrow;
    assign bus.overflow  = r_overflow;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table, reset abort
// sequence and randomized operations against an arithmetic model.
module tb_serial_subtractor;
    localparam int DW = 8;
    localparam int NSTEP = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.DATA_WID(DW)) bus ();

    serial_subtractor #(
        .DATA_WID  (DW),
        .DIGIT_WID (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e_out;
        logic       e_borrow;
        logic       e_ovf;
        int         stall;
        int         hold;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: plain modular and signed arithmetic.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] o, output logic bo,
                         output logic ov);
        int sa;
        int sb;
        int sd;
        sa = $signed(a);
        sb = $signed(b);
        sd = sa - sb;
        o  = 8'((int'(a) - int'(b)) & 255);
        bo = (int'(a) < int'(b));
        ov = (sd > 127) || (sd < -128);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] e_out,
                          input logic e_bo, input logic e_ov,
                          input int stall, input int hold);
        int lat;
        int g;
        logic [7:0] so;
        logic sb;
        logic sv;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            tick();
            g++;
        end
        chk({tag, " in_ready idle"}, 32'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.enable    = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.a = 8'hxx;
        bus.b = 8'hxx;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            if (lat == 1 && stall > 0) bus.enable = 1'b0;
            if (lat == 1 + stall) bus.enable = 1'b1;
            tick();
            lat++;
        end
        bus.enable = 1'b1;
        chk({tag, " latency"}, 32'(lat), 32'(NSTEP + stall));
        chk({tag, " out"}, 32'(bus.out), 32'(e_out));
        chk({tag, " borrow"}, 32'(bus.borrow), 32'(e_bo));
        chk({tag, " overflow"}, 32'(bus.overflow), 32'(e_ov));
        so = bus.out;
        sb = bus.borrow;
        sv = bus.overflow;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a = ~a;
            bus.b = a;
            tick();
            bus.in_valid = 1'b0;
            chk({tag, " hold valid"}, 32'(bus.out_valid), 1);
            chk({tag, " hold in_ready"}, 32'(bus.in_ready), 0);
            chk({tag, " hold out"},
                32'({bus.out, bus.borrow, bus.overflow}),
                32'({so, sb, sv}));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, " valid drop"}, 32'(bus.out_valid), 0);
        chk({tag, " in_ready back"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] mo;
        logic       mb;
        logic       mv;
        checks = 0;
        errors = 0;

        vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 0, 0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0, 0};
        vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 0, 0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 0};
        vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0, 0};
        vecs[5] = '{8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0, 2, 5};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.enable    = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst in_ready", 32'(bus.in_ready), 1);
        chk("rst out_valid", 32'(bus.out_valid), 0);
        chk("rst out", 32'(bus.out), 0);
        chk("rst flags", 32'({bus.borrow, bus.overflow}), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].e_out, vecs[i].e_borrow, vecs[i].e_ovf,
                   vecs[i].stall, vecs[i].hold);
        end

        // Abort a run with reset two cycles after accept.
        bus.in_valid = 1'b1;
        bus.a = 8'h33;
        bus.b = 8'h11;
        bus.enable = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(bus.out_valid), 0);
        chk("abort out", 32'(bus.out), 0);
        chk("abort flags", 32'({bus.borrow, bus.overflow}), 0);
        chk("abort in_ready", 32'(bus.in_ready), 1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort no pulse", 32'(bus.out_valid), 0);
        end
        run_op("post-rst", 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 0) rb = ra;
            model(ra, rb, mo, mb, mv);
            run_op($sformatf("rnd%0d %h-%h", i, ra, rb), ra, rb,
                   mo, mb, mv, int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
